// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the classifier back-end.
//   DEFAULT_BITS   : default score width (two's complement)
//   DEFAULT_HEIGHT : default number of classes per inference
//   IDX_W          : class index / counter width for the default HEIGHT
//   argmax_state_t : sequencer states of argmax_seq_ctrl
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int DEFAULT_BITS   = 24;
    localparam int DEFAULT_HEIGHT = 10;
    localparam int IDX_W          = $clog2(DEFAULT_HEIGHT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_update.sv
// ---------------------------------------------------------------------------
// argmax_update
// Combinational compare-and-select step of the sequential argmax. One signed
// comparator is shared by every beat of an inference.
// Ports:
//   first    in  : current beat is beat 0 (load unconditionally)
//   in_data  in  : incoming score (signed)
//   max      in  : running maximum so far
//   idx      in  : index of the running maximum
//   cnt      in  : index of the incoming score
//   next_max out : running maximum after this beat
//   next_idx out : winning index after this beat
// ---------------------------------------------------------------------------
module argmax_update
    import nn_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int IW   = IDX_W
) (
    input  logic            first,
    input  logic [BITS-1:0] in_data,
    input  logic [BITS-1:0] max,
    input  logic [IW-1:0]   idx,
    input  logic [IW-1:0]   cnt,
    output logic [BITS-1:0] next_max,
    output logic [IW-1:0]   next_idx
);

    // Strict greater-than keeps the earlier index on ties.
    always_comb begin
        next_max = max;
        next_idx = idx;
        if (first) begin
            next_max = in_data;
            next_idx = '0;
        end else if ($signed(in_data) > $signed(max)) begin
            next_max = in_data;
            next_idx = cnt;
        end
    end

endmodule

// File: rtl/argmax_seq_ctrl.sv
// ---------------------------------------------------------------------------
// argmax_seq_ctrl
// Sequential classifier back-end: takes HEIGHT signed scores one per cycle on
// a valid/ready stream, tracks the running maximum with a single comparator
// and presents the winning class index on an output valid/ready handshake.
//
// Optional feature macro: ARGMAX_SCORE_OUT_EN
//   defined     -> adds output max_score carrying the winning score
//   not defined -> no max_score port
//
// Ports:
//   clk         in  : rising-edge clock
//   reset       in  : asynchronous active-high reset
//   start       in  : begins an inference (IDLE, or DONE with handshake)
//   in_valid    in  : score beat present
//   in_data     in  : score for the current class (signed)
//   in_ready    out : block accepts scores (registered, high in COLLECT)
//   out_valid   out : predict_num valid (registered, high in DONE)
//   out_ready   in  : downstream accepts the result
//   predict_num out : winning class index, zero-extended to BITS
//   busy        out : high in COLLECT or DONE
//   max_score   out : winning score (only with ARGMAX_SCORE_OUT_EN)
// ---------------------------------------------------------------------------
module argmax_seq_ctrl
    import nn_pkg::*;
#(
    parameter int BITS   = DEFAULT_BITS,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] predict_num,
    output logic            busy
`ifdef ARGMAX_SCORE_OUT_EN
    ,
    output logic [BITS-1:0] max_score
`endif
);

    localparam int IW = $clog2(HEIGHT);
    localparam logic [IW-1:0] LAST_CNT = IW'(HEIGHT - 1);

    argmax_state_t   state;
    logic [IW-1:0]   cnt;
    logic [BITS-1:0] max_val;
    logic [IW-1:0]   idx_val;

    logic [BITS-1:0] next_max;
    logic [IW-1:0]   next_idx;
    logic            beat;

    // in_ready is a registered decode of COLLECT, so a beat is simply
    // in_valid while the handshake output is high.
    assign beat = in_valid && in_ready;

    argmax_update #(
        .BITS (BITS),
        .IW   (IW)
    ) u_update (
        .first    (cnt == '0),
        .in_data  (in_data),
        .max      (max_val),
        .idx      (idx_val),
        .cnt      (cnt),
        .next_max (next_max),
        .next_idx (next_idx)
    );

    // Sequencer, counter and result registers. All handshake outputs are
    // assigned here alongside the state so they stay pure state decodes.
    // predict_num (and max_score) only load on the entry into DONE, so they
    // hold the previous result through IDLE and COLLECT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            max_val     <= '0;
            idx_val     <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            predict_num <= '0;
            busy        <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
            max_score   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        cnt      <= '0;
                        max_val  <= '0;
                        idx_val  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (beat) begin
                        max_val <= next_max;
                        idx_val <= next_idx;
                        cnt     <= cnt + IW'(1);
                        if (cnt == LAST_CNT) begin
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
                            predict_num <= {{(BITS-IW){1'b0}}, next_idx};
`ifdef ARGMAX_SCORE_OUT_EN
                            max_score   <= next_max;
`endif
                        end
                    end
                end

                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back inference: skip IDLE entirely.
                            state    <= COLLECT;
                            cnt      <= '0;
                            max_val  <= '0;
                            idx_val  <= '0;
                            in_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_argmax_seq_ctrl
// Self-checking bench for argmax_seq_ctrl: a table of directed score sets,
// a reset-mid-inference sequence and a randomized phase checked against a
// plain argmax reference. Builds with or without ARGMAX_SCORE_OUT_EN.
// ---------------------------------------------------------------------------
module tb_argmax_seq_ctrl;

    localparam int BITS   = 24;
    localparam int HEIGHT = 10;

    typedef logic [HEIGHT-1:0][BITS-1:0] score_set_t;

    typedef struct {
        string      name;
        score_set_t s;
        int         exp_idx;
        logic [BITS-1:0] exp_max;
        int         gap_pct;
        int         hold;
        bit         b2b;
    } vec_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] predict_num;
    logic            busy;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [BITS-1:0] max_score;
`endif

    int checks = 0;
    int failures = 0;
    int cycle_count = 0;
    int c0 = 0;
    bit prev_b2b = 0;

    vec_t vecs[4];

    argmax_seq_ctrl #(
        .BITS   (BITS),
        .HEIGHT (HEIGHT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .predict_num (predict_num),
        .busy        (busy)
`ifdef ARGMAX_SCORE_OUT_EN
        ,
        .max_score   (max_score)
`endif
    );

    // Free-running clock and cycle counter used for latency measurement.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Reference argmax: first index holding the largest signed score.
    task automatic ref_argmax(input score_set_t s, output int best,
                              output logic [BITS-1:0] best_val);
        best = 0;
        for (int i = 1; i < HEIGHT; i++) begin
            if ($signed(s[i]) > $signed(s[best])) best = i;
        end
        best_val = s[best];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d",
                     name, actual, expected, cycle_count);
        end
    endtask

    task automatic fill_vec(input int k, input string name, input int sc[HEIGHT],
                            input int exp_idx, input logic [BITS-1:0] exp_max,
                            input int gap_pct, input int hold, input bit b2b);
        vecs[k].name = name;
        for (int i = 0; i < HEIGHT; i++) vecs[k].s[i] = BITS'(sc[i]);
        vecs[k].exp_idx = exp_idx;
        vecs[k].exp_max = exp_max;
        vecs[k].gap_pct = gap_pct;
        vecs[k].hold    = hold;
        vecs[k].b2b     = b2b;
    endtask

    // Entered at a negedge while the DUT is idle.
    task automatic start_inference();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cycle_count;
        checkOutput("in_ready_after_start", in_ready, 1);
        checkOutput("busy_after_start", busy, 1);
    endtask

    // Streams one score set with optional random gaps; start pulses during
    // gaps must be ignored by the DUT.
    task automatic applyStimulus(input score_set_t s, input int gap_pct,
                                 input bit poke_start);
        int i = 0;
        int guard = 0;
        while (i < HEIGHT && guard < 400) begin
            checkOutput("out_valid_low_collect", out_valid, 0);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = BITS'($urandom);
                start    = poke_start ? 1'($urandom_range(1)) : 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = s[i];
                start    = 1'b0;
                if (in_ready) i++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checkOutput("stream_complete", i, HEIGHT);
    endtask

    // Waits for the result, holds out_ready low for a while, then handshakes
    // (optionally with start in the same cycle).
    task automatic finish_inference(input int exp_idx, input logic [BITS-1:0] exp_max,
                                    input int hold, input bit b2b, input bit check_lat);
        int w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("out_valid_done", out_valid, 1);
        if (check_lat) checkOutput("latency", cycle_count - c0 + 1, HEIGHT + 1);
        checkOutput("predict_num", predict_num, exp_idx);
        checkOutput("busy_done", busy, 1);
        checkOutput("in_ready_done", in_ready, 0);
`ifdef ARGMAX_SCORE_OUT_EN
        checkOutput("max_score", max_score, exp_max);
`else
        if (exp_max === 'x) $display("[TB] note: unknown expected max");
`endif
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(1));
            @(negedge clk);
            checkOutput("predict_hold", predict_num, exp_idx);
            checkOutput("out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        start     = b2b;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        checkOutput("out_valid_after_hs", out_valid, 0);
        checkOutput("in_ready_after_hs", in_ready, b2b);
        checkOutput("busy_after_hs", busy, b2b);
        checkOutput("predict_after_hs", predict_num, exp_idx);
        if (b2b) c0 = cycle_count;
    endtask

    task automatic random_set(output score_set_t s);
        for (int i = 0; i < HEIGHT; i++) begin
            case ($urandom_range(2))
                0: s[i] = BITS'($urandom);
                1: s[i] = BITS'(int'($urandom_range(6)) - 3);
                default: begin
                    case ($urandom_range(3))
                        0: s[i] = 24'h800000;
                        1: s[i] = 24'h7FFFFF;
                        2: s[i] = 24'h000000;
                        default: s[i] = 24'hFFFFFF;
                    endcase
                end
            endcase
        end
    endtask

    initial begin
        int sc[HEIGHT];
        score_set_t rs;
        int r_idx;
        logic [BITS-1:0] r_max;
        int gap;
        int hold;
        bit b2b;

        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        sc = '{3, -1, 7, 2, 0, 7, -5, 1, 4, 6};
        fill_vec(0, "plan_tie", sc, 2, 24'd7, 0, 0, 1'b0);
        sc = '{-8388608, -8388608, -8388608, -8388608, -8388608,
               -8388608, -8388608, -8388608, -8388608, -8388608};
        fill_vec(1, "all_min", sc, 0, 24'h800000, 0, 5, 1'b1);
        sc = '{-8, -7, -6, -5, -4, -3, -2, -8, -8, -1};
        fill_vec(2, "neg_last", sc, 9, 24'hFFFFFF, 30, 2, 1'b0);
        sc = '{-8388608, -8388608, -8388608, -8388608, -8388608,
               -8388608, -8388608, -8388608, -8388608, 8388607};
        fill_vec(3, "extremes", sc, 9, 24'h7FFFFF, 0, 0, 1'b0);

        // Reset state.
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_predict", predict_num, 0);
        checkOutput("rst_busy", busy, 0);
`ifdef ARGMAX_SCORE_OUT_EN
        checkOutput("rst_max_score", max_score, 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 0);

        // Directed table.
        prev_b2b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            $display("[TB] vector %s", vecs[k].name);
            if (!prev_b2b) start_inference();
            applyStimulus(vecs[k].s, vecs[k].gap_pct, 1'b1);
            finish_inference(vecs[k].exp_idx, vecs[k].exp_max, vecs[k].hold,
                             vecs[k].b2b, vecs[k].gap_pct == 0);
            prev_b2b = vecs[k].b2b;
        end

        // Reset after beat 4 discards the partial inference.
        start_inference();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = BITS'(100 + i);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_predict", predict_num, 0);
        checkOutput("midrst_busy", busy, 0);
`ifdef ARGMAX_SCORE_OUT_EN
        checkOutput("midrst_max_score", max_score, 0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("postrst_out_valid", out_valid, 0);
            checkOutput("postrst_busy", busy, 0);
        end
        random_set(rs);
        ref_argmax(rs, r_idx, r_max);
        start_inference();
        applyStimulus(rs, 0, 1'b0);
        finish_inference(r_idx, r_max, 1, 1'b0, 1'b1);

        // Randomized inferences with gaps, holds and back-to-back starts.
        prev_b2b = 1'b0;
        for (int n = 0; n < 12; n++) begin
            random_set(rs);
            ref_argmax(rs, r_idx, r_max);
            gap  = (n % 3 == 0) ? 0 : int'($urandom_range(40));
            hold = int'($urandom_range(5));
            b2b  = (n == 11) ? 1'b0 : 1'($urandom_range(1));
            if (!prev_b2b) start_inference();
            applyStimulus(rs, gap, 1'b1);
            finish_inference(r_idx, r_max, hold, b2b, gap == 0);
            prev_b2b = b2b;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/argmax_seq_ctrl.md
# argmax_seq_ctrl

Sequential classifier back-end that sequences the final decision of the network. It accepts the `HEIGHT` class scores from the fully connected layer one per cycle over a valid/ready stream and keeps a running signed maximum. It then presents the winning class index with an output valid/ready handshake. It replaces the wide combinational compare across all scores with a single comparator reused over `HEIGHT` cycles.

## Interface
- `BITS`, 24: score width, two's complement.
- `HEIGHT`, 10: number of classes per inference (≥2).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins an inference; ignored unless in IDLE, or DONE with a handshake in the same cycle.
- `in_valid`  in  1  a score beat is present.
- `in_data`  in  `BITS`  score for class `cnt` (signed).
- `in_ready`  out  1  block can accept a score.
- `out_valid`  out  1  `predict_num` is valid.
- `out_ready`  in  1  downstream accepts the result.
- `predict_num`  out  `BITS`  winning class index, zero-extended.
- `busy`  out  1  high in COLLECT or DONE.

## Operation
- States:
  - IDLE: waits for `start`.
  - COLLECT: accepts scores.
  - DONE: holds the result.
- IDLE → COLLECT on `start`: clear `cnt` to 0, clear `max` and `idx`.
- COLLECT:
  - `in_ready` = 1. A beat transfers when `in_valid && in_ready`.
  - Beat 0 loads `max` = `in_data` and `idx` = 0 unconditionally.
  - Beat k>0 replaces `max`/`idx` only if `signed'(in_data) > signed'(max)`. Ties keep the lower index.
  - `cnt` increments per beat. The beat with `cnt == HEIGHT-1` moves to DONE.
  - Cycles with `in_valid` low stall, with no state change.
- DONE:
  - `out_valid` = 1 and `predict_num` = `idx`, both stable until the handshake.
  - On `out_valid && out_ready`: go to IDLE, or to COLLECT if `start` is high in the same cycle (back-to-back inference).
- `start` during COLLECT or during DONE without a handshake is ignored. It is not queued.
- Arithmetic: strict signed compare over the full `BITS` width. The most negative value is legal. `cnt` and `idx` are `$clog2(HEIGHT)` bits.
- Reset values, asynchronous, taking effect immediately:
  - state IDLE, `cnt` 0, `max` 0, `idx` 0.
  - `in_ready` 0, `out_valid` 0, `predict_num` 0, `busy` 0.
- Reset mid-inference discards the partial result. No `out_valid` is produced for it.

## Timing
- `in_ready` and `out_valid` are registered state decodes, not combinational from the inputs.
- Latency: `out_valid` rises in the cycle after the last beat is accepted. With no stalls that is `HEIGHT`+1 cycles after `start`.
- Minimum period per inference with `out_ready` tied high and `start` re-asserted on the handshake is `HEIGHT`+1 cycles.
- `predict_num` changes only on the transition into DONE. It holds its last value in IDLE and COLLECT, and is reset to 0.

## Configuration
- `ARGMAX_SCORE_OUT_EN` defined: adds output `max_score [BITS-1:0]`, which carries the winning score. It is valid and stable with `out_valid`, under the same hold rules as `predict_num`, and its reset value is 0.
- Not defined: the port is absent. `max` stays internal and is pruned where unused.

## Structure
- Shared package `nn_pkg` holds:
  - the `BITS` and `HEIGHT` defaults;
  - `localparam IDX_W = $clog2(HEIGHT)`;
  - the `typedef enum logic [1:0] {IDLE, COLLECT, DONE} argmax_state_t`.
- One sub-module is natural: `argmax_update`, the combinational compare-and-select.
  - Inputs: `first`, `in_data`, `max`, `idx`, `cnt`.
  - Outputs: next `max`, next `idx`.
- The FSM, counter and registers stay in `argmax_seq_ctrl`.

## Test plan
- Scores 3,−1,7,2,0,7,−5,1,4,6 streamed without stalls, `out_ready`=1 → `predict_num`=2 (tie at 5 is ignored), `out_valid` at cycle 11 after `start`, `max_score`=7 if enabled.
- All ten scores = 24'h800000 (most negative) → `predict_num`=0. Scores −8..−1 with the last class = −1 → `predict_num`=9.
- Random `in_valid` gaps plus `out_ready` held low 5 cycles in DONE → result correct and `predict_num` stable throughout. `start` pulses inside COLLECT/DONE are ignored.
- Back-to-back: `start` asserted in the same cycle as the DONE handshake → second inference begins with no IDLE cycle. Both results match the reference argmax.
- `reset` asserted after beat 4 → all outputs 0 immediately, no `out_valid`. A new `start` then gives the correct result for a fresh 10-score set.
- Macro build matrix: compile with and without `ARGMAX_SCORE_OUT_EN` → port presence matches, and the `predict_num` traces are identical across both builds.
